// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART configuration types
package uart_pkg;
  typedef enum logic [1:0] {
    HALF_PERIOD          = 2'd0,
    ONE_PERIOD           = 2'd1,
    ONE_AND_HALF_PERIODS = 2'd2,
    TWO_PERIODS          = 2'd3
  } stop_bit_mode_t;
endpackage

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver; UART_RX_MAJORITY_VOTE_EN selects 2-of-3 sampling
module uart_rx
  import uart_pkg::*;
(
  input  logic           i_clk,
  input  logic           i_nrst,
  input  logic           i_rx,
  input  logic [31:0]    i_bit_length,
  input  logic           i_parity_enable,
  input  stop_bit_mode_t i_stop_bit_mode,
  input  logic           i_msb_first,
  input  logic           i_hw_flow_control_enable,
  input  logic           i_fifo_full,
  output logic           o_valid,
  output logic [7:0]     o_data,
  output logic           o_parity_err,
  output logic           o_frame_err,
  output logic           o_break,
  output logic           o_overrun,
  output logic           o_rts,
  output logic           o_rx_status
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DONE
  } state_t;

  state_t         state, state_nx;
  logic           rx_m, rx_s, rx_prev;
  logic [1:0]     warm;
  logic           pending;
  logic [31:0]    cnt, bl;
  logic           par_en, msb;
  stop_bit_mode_t stop_mode;
  logic [2:0]     bit_idx;
  logic [7:0]     shreg, data_q;
  logic           par_bit, stop_bit, perr_q, ferr_q;
  logic           samp, fall, start_go, perr_now, brk_now;
  logic [31:0]    mid, start_pt, stop_pt;

  assign mid      = bl >> 1;
  assign stop_pt  = (stop_mode == HALF_PERIOD) ? mid + (bl >> 2) : bl;
  assign fall     = rx_prev & ~rx_s;
  assign start_go = (state == S_IDLE) && (fall || (pending && !rx_s));
  assign perr_now = par_en && (par_bit != ^shreg);
  assign brk_now  = (shreg == 8'h00) && !stop_bit && (!par_en || !par_bit);

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic rx_h1, rx_h2;

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      rx_h1 <= 1'b1;
      rx_h2 <= 1'b1;
    end else begin
      rx_h1 <= rx_s;
      rx_h2 <= rx_h1;
    end
  end

  // Votes over target-1..target+1, so every decision lands one clock later;
  // shifting the start check shifts the whole frame timebase with it.
  assign samp     = (rx_h2 & rx_h1) | (rx_h2 & rx_s) | (rx_h1 & rx_s);
  assign start_pt = mid + 32'd1;
`else
  assign samp     = rx_s;
  assign start_pt = mid;
`endif

  assign o_rts       = i_hw_flow_control_enable ? !i_fifo_full : 1'b1;
  assign o_rx_status = (state != S_IDLE);

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) state <= S_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    o_valid      = 1'b0;
    o_overrun    = 1'b0;
    o_break      = 1'b0;
    o_data       = data_q;
    o_parity_err = perr_q;
    o_frame_err  = ferr_q;
    case (state)
      S_IDLE:   if (start_go) state_nx = S_START;
      S_START:  if (cnt == start_pt) state_nx = samp ? S_IDLE : S_DATA;
      S_DATA:   if (cnt == bl && bit_idx == 3'd7) state_nx = par_en ? S_PARITY : S_STOP;
      S_PARITY: if (cnt == bl) state_nx = S_STOP;
      S_STOP:   if (cnt == stop_pt) state_nx = S_DONE;
      S_DONE: begin
        state_nx = S_IDLE;
        o_break  = brk_now;
        if (i_fifo_full) begin
          o_overrun = 1'b1;
        end else begin
          o_valid      = 1'b1;
          o_data       = shreg;
          o_parity_err = perr_now;
          o_frame_err  = !stop_bit;
        end
      end
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      rx_m      <= 1'b1;
      rx_s      <= 1'b1;
      rx_prev   <= 1'b0;
      warm      <= 2'd0;
      pending   <= 1'b0;
      cnt       <= 32'd0;
      bl        <= 32'd0;
      par_en    <= 1'b0;
      msb       <= 1'b0;
      stop_mode <= ONE_PERIOD;
      bit_idx   <= 3'd0;
      shreg     <= 8'h00;
      data_q    <= 8'h00;
      par_bit   <= 1'b0;
      stop_bit  <= 1'b1;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      rx_m <= i_rx;
      rx_s <= rx_m;
      // Edge history stays masked until the synchroniser holds real line
      // values, so a line already low out of reset never looks like a start.
      if (warm != 2'd2) warm <= warm + 2'd1;
      rx_prev <= (warm == 2'd2) ? rx_s : 1'b0;
      pending <= (state == S_DONE) && fall;
      cnt     <= cnt + 32'd1;
      case (state)
        S_IDLE: begin
          cnt <= 32'd0;
          if (start_go) begin
            bl        <= i_bit_length;
            par_en    <= i_parity_enable;
            stop_mode <= i_stop_bit_mode;
            msb       <= i_msb_first;
            bit_idx   <= 3'd0;
          end
        end
        S_START: if (cnt == start_pt) cnt <= 32'd0;
        S_DATA: begin
          if (cnt == bl) begin
            cnt <= 32'd0;
            shreg[msb ? ~bit_idx : bit_idx] <= samp;
            bit_idx <= bit_idx + 3'd1;
          end
        end
        S_PARITY: begin
          if (cnt == bl) begin
            cnt     <= 32'd0;
            par_bit <= samp;
          end
        end
        S_STOP: if (cnt == stop_pt) stop_bit <= samp;
        S_DONE: begin
          if (!i_fifo_full) begin
            data_q <= shreg;
            perr_q <= perr_now;
            ferr_q <= !stop_bit;
          end
        end
        default: cnt <= 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - randomized self-checking bench for uart_rx
module tb_uart_rx;
  import uart_pkg::*;

`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam bit MAJ = 1'b1;
`else
  localparam bit MAJ = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           i_nrst;
  logic           i_rx;
  logic [31:0]    i_bit_length;
  logic           i_parity_enable;
  stop_bit_mode_t i_stop_bit_mode;
  logic           i_msb_first;
  logic           i_hw_flow_control_enable;
  logic           i_fifo_full;
  logic           o_valid, o_parity_err, o_frame_err, o_break, o_overrun, o_rts, o_rx_status;
  logic [7:0]     o_data;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int t_start;

  typedef struct packed {
    logic       v;
    logic       ovr;
    logic       brk;
    logic       pe;
    logic       fe;
    logic [7:0] d;
  } ev_t;

  ev_t evq[$];
  int  ev_cyc[$];

  uart_rx dut (
    .i_clk                   (clk),
    .i_nrst                  (i_nrst),
    .i_rx                    (i_rx),
    .i_bit_length            (i_bit_length),
    .i_parity_enable         (i_parity_enable),
    .i_stop_bit_mode         (i_stop_bit_mode),
    .i_msb_first             (i_msb_first),
    .i_hw_flow_control_enable(i_hw_flow_control_enable),
    .i_fifo_full             (i_fifo_full),
    .o_valid                 (o_valid),
    .o_data                  (o_data),
    .o_parity_err            (o_parity_err),
    .o_frame_err             (o_frame_err),
    .o_break                 (o_break),
    .o_overrun               (o_overrun),
    .o_rts                   (o_rts),
    .o_rx_status             (o_rx_status)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (o_valid || o_overrun || o_break) begin
      evq.push_back('{v: o_valid, ovr: o_overrun, brk: o_break,
                      pe: o_parity_err, fe: o_frame_err, d: o_data});
      ev_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_bits(input int n);
    repeat (n * (int'(i_bit_length) + 1)) @(posedge clk);
    #1;
  endtask

  task automatic clear_events();
    evq.delete();
    ev_cyc.delete();
  endtask

  // Line bit k of the frame is lb[k]; glitch_bit inverts one clock at that bit's centre.
  task automatic drive_frame(input logic [7:0] lb, input logic par_wrong,
                             input logic stop_low, input int glitch_bit);
    int half;
    half = int'(i_bit_length >> 1);
    i_rx = 1'b0;
    t_start = cyc;
    wait_bits(1);
    for (int k = 0; k < 8; k++) begin
      i_rx = lb[k];
      if (k == glitch_bit) begin
        repeat (half + 1) @(posedge clk);
        #1 i_rx = ~lb[k];
        @(posedge clk);
        #1 i_rx = lb[k];
        repeat (int'(i_bit_length) + 1 - half - 2) @(posedge clk);
        #1;
      end else begin
        wait_bits(1);
      end
    end
    if (i_parity_enable) begin
      i_rx = (^lb) ^ par_wrong;
      wait_bits(1);
    end
    i_rx = !stop_low;
    wait_bits(1);
    i_rx = 1'b1;
  endtask

  task automatic run_frame(input string tag, input logic [7:0] lb, input logic par_wrong,
                           input logic stop_low, input logic full, input int glitch_bit);
    logic [7:0] lbe, exp_d;
    logic       exp_brk, exp_pe;
    i_fifo_full = full;
    repeat (2) @(posedge clk);
    #1;
    check({tag, "_rts"}, o_rts, i_hw_flow_control_enable ? !full : 1'b1);
    clear_events();
    drive_frame(lb, par_wrong, stop_low, glitch_bit);
    wait_bits(3);
    lbe = lb;
    if (glitch_bit >= 0 && !MAJ) lbe[glitch_bit] = ~lbe[glitch_bit];
    for (int k = 0; k < 8; k++) exp_d[i_msb_first ? 7 - k : k] = lbe[k];
    exp_pe  = i_parity_enable && ((^lbe) != ((^lb) ^ par_wrong));
    exp_brk = (lbe == 8'h00) && stop_low && (!i_parity_enable || !par_wrong);
    check({tag, "_events"}, evq.size(), 1);
    if (evq.size() > 0) begin
      check({tag, "_valid"}, evq[0].v, !full);
      check({tag, "_overrun"}, evq[0].ovr, full);
      check({tag, "_break"}, evq[0].brk, exp_brk);
      if (!full) begin
        check({tag, "_data"}, evq[0].d, exp_d);
        check({tag, "_perr"}, evq[0].pe, exp_pe);
        check({tag, "_ferr"}, evq[0].fe, stop_low);
      end
    end
    i_fifo_full = 1'b0;
  endtask

  initial begin
    i_nrst = 1'b0;
    i_rx = 1'b1;
    i_bit_length = 32'd15;
    i_parity_enable = 1'b0;
    i_stop_bit_mode = ONE_PERIOD;
    i_msb_first = 1'b0;
    i_hw_flow_control_enable = 1'b0;
    i_fifo_full = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", o_valid, 1'b0);
    check("rst_data", o_data, 8'h00);
    check("rst_flags", {o_parity_err, o_frame_err, o_break, o_overrun}, 4'h0);
    check("rst_status", o_rx_status, 1'b0);
    check("rst_rts", o_rts, 1'b1);
    i_nrst = 1'b1;
    wait_bits(2);

    run_frame("a5", 8'hA5, 1'b0, 1'b0, 1'b0, -1);
    if (ev_cyc.size() > 0)
      check("a5_latency", ((ev_cyc[0] - t_start) >= 153) && ((ev_cyc[0] - t_start) <= 157), 1'b1);

    i_parity_enable = 1'b1;
    run_frame("par3c", 8'h3C, 1'b1, 1'b0, 1'b0, -1);
    i_parity_enable = 1'b0;

    i_msb_first = 1'b1;
    run_frame("msb01", 8'h01, 1'b0, 1'b1, 1'b0, -1);
    i_msb_first = 1'b0;

    clear_events();
    i_rx = 1'b0;
    wait_bits(12);
    check("brk_events_low", evq.size(), 1);
    if (evq.size() > 0) begin
      check("brk_pulse", evq[0].brk, 1'b1);
      check("brk_ferr", evq[0].fe, 1'b1);
      check("brk_data", evq[0].d, 8'h00);
    end
    i_rx = 1'b1;
    wait_bits(2);
    check("brk_events_after", evq.size(), 1);

    i_hw_flow_control_enable = 1'b1;
    run_frame("full", 8'h77, 1'b0, 1'b0, 1'b1, -1);
    i_hw_flow_control_enable = 1'b0;

    clear_events();
    i_rx = 1'b0;
    @(posedge clk);
    #1 i_rx = 1'b1;
    wait_bits(2);
    check("glitch_events", evq.size(), 0);
    check("glitch_status", o_rx_status, 1'b0);

    run_frame("datglitch", 8'h5A, 1'b0, 1'b0, 1'b0, 3);

    clear_events();
    drive_frame(8'h96, 1'b0, 1'b0, -1);
    drive_frame(8'h4B, 1'b0, 1'b0, -1);
    wait_bits(3);
    check("b2b_events", evq.size(), 2);
    if (evq.size() == 2) begin
      check("b2b_d0", evq[0].d, 8'h96);
      check("b2b_d1", evq[1].d, 8'h4B);
    end

    clear_events();
    i_rx = 1'b0;
    wait_bits(2);
    i_nrst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mid_status", o_rx_status, 1'b0);
    i_nrst = 1'b1;
    wait_bits(3);
    check("rst_mid_events", evq.size(), 0);
    check("rst_mid_idle", o_rx_status, 1'b0);
    i_rx = 1'b1;
    wait_bits(2);
    run_frame("post_rst", 8'hC3, 1'b0, 1'b0, 1'b0, -1);

    for (int f = 0; f < 24; f++) begin
      logic pw;
      i_bit_length             = 32'($urandom_range(24, 7));
      i_parity_enable          = 1'($urandom_range(1, 0));
      i_msb_first              = 1'($urandom_range(1, 0));
      i_stop_bit_mode          = stop_bit_mode_t'($urandom_range(3, 0));
      i_hw_flow_control_enable = 1'($urandom_range(1, 0));
      pw = i_parity_enable && ($urandom_range(3, 0) == 0);
      wait_bits(1);
      run_frame($sformatf("rnd%0d", f), 8'($urandom), pw,
                1'($urandom_range(4, 0) == 0), 1'($urandom_range(5, 0) == 0), -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver paired with the existing transmitter. It deserialises asynchronous frames from the line: start bit, 8 data bits, optional even parity, then stop bit(s). Each received byte is pushed into the RX FIFO with per-byte error flags. The block sits between the pad-side RX input and the RX FIFO and uses the same configuration registers as the TX path (`uart_pkg`).

## Interface
- No parameters. Types come from `uart_pkg`: `stop_bit_mode_t` with encodings HALF_PERIOD=0, ONE_PERIOD=1, ONE_AND_HALF_PERIODS=2, TWO_PERIODS=3.
- Reset i_nrst, asynchronous, active-low; clock i_clk.
- i_clk  in  1  system clock
- i_nrst  in  1  async active-low reset
- i_rx  in  1  serial line, asynchronous to i_clk, idle high
- i_bit_length  in  32  bit period in clocks minus 1; legal values ≥3
- i_parity_enable  in  1  expect an even-parity bit after the data
- i_stop_bit_mode  in  stop_bit_mode_t  stop bit length
- i_msb_first  in  1  first data bit on the line is bit 7
- i_hw_flow_control_enable  in  1  enables RTS generation
- i_fifo_full  in  1  RX FIFO full
- o_valid  out  1  one-cycle push strobe to the FIFO
- o_data  out  8  received byte
- o_parity_err  out  1  parity mismatch; qualified by o_valid
- o_frame_err  out  1  first stop bit sampled low; qualified by o_valid
- o_break  out  1  one-cycle pulse: data = 0x00, parity (if enabled) = 0, stop = 0
- o_overrun  out  1  one-cycle pulse: byte dropped because i_fifo_full
- o_rts  out  1  `i_hw_flow_control_enable ? !i_fifo_full : 1`, combinational
- o_rx_status  out  1  high whenever the state is not IDLE

## Operation
- i_rx passes through a 2-flop synchroniser; all logic below uses the synchronised value `rx_s`.
- i_bit_length, i_parity_enable, i_stop_bit_mode and i_msb_first are latched on IDLE→START. Changes mid-frame have no effect.
- Bit counter counts 0..bit_length, giving bit_length+1 clocks per bit. `mid` = bit_length>>1.
- FSM states: IDLE, START, DATA, PARITY, STOP, DONE.
  - IDLE: a falling edge of `rx_s` (1→0) moves to START with counter=0.
  - START: at counter==mid, sample the line. If 0, clear the counter and go to DATA. If 1, treat as a false start and return to IDLE with no outputs.
  - DATA: at counter==bit_length, sample the bit and clear the counter. After 8 samples go to PARITY if parity is enabled, otherwise to STOP.
  - Data assembly: LSB-first puts sample k into bit k; msb_first puts sample k into bit 7-k.
  - PARITY: at counter==bit_length, sample the bit. Parity error = sample != ^data.
  - STOP: sample at counter==bit_length, or at counter==mid+(bit_length>>2) for HALF_PERIOD mode. A 0 sample sets frame error. Then go to DONE.
  - Only the first stop bit is checked in every mode. The remaining stop time is spent in IDLE, which allows resync to a following start edge.
  - DONE lasts one cycle, then returns to IDLE.
- Outputs in DONE:
  - If !i_fifo_full: o_valid=1 with o_data, o_parity_err and o_frame_err.
  - If i_fifo_full: o_valid=0 and o_overrun=1. Data and flags are discarded.
  - o_break is asserted independently of i_fifo_full.
- o_data and the error flags hold their values between strobes.

## Timing
- Reset values:
  - o_valid, o_parity_err, o_frame_err, o_break, o_overrun = 0; o_data = 0x00; o_rx_status = 0.
  - o_rts follows its combinational equation.
  - Synchroniser flops reset to 1; state = IDLE.
- Reset asserted mid-frame aborts immediately with no strobe. The receiver then waits for a fresh falling edge; a line already held low does not start a frame.
- Start-edge detection lags i_rx by 2–3 clocks (synchroniser).
- o_valid follows the stop-bit sample by exactly 1 clock.
- A falling edge that arrives during DONE is not lost. It is detected in IDLE on the next cycle, provided `rx_s` is still low.
- Back-to-back frames with 1 stop bit are received without loss at the nominal bit_length.

## Configuration
- `UART_RX_MAJORITY_VOTE_EN` defined:
  - Each sample point (start, data, parity, stop) is the 2-of-3 majority of `rx_s` at target-1, target and target+1.
  - The decision and its state action happen at target+1.
  - The start-bit check uses the same vote.
- Not defined: a single sample at the target count.
- All other behaviour is identical in both builds.

## Test plan
- bit_length=15, no parity, ONE_PERIOD, LSB-first, frame 0xA5 with the start edge at cycle T → exactly one o_valid, o_data=0xA5, no error flags, strobe within T+155±2.
- Same settings with parity enabled and a wrong parity bit on the line for 0x3C → o_valid with o_data=0x3C and o_parity_err=1.
- msb_first=1, line carries 0x01 LSB-first order → o_data=0x80. Stop bit forced low → o_frame_err=1.
- Line low for 12 bit periods → o_break=1, o_frame_err=1, o_data=0x00. No second frame until the line returns high and falls again.
- i_fifo_full=1 during the frame → o_overrun pulse, no o_valid. With hw flow control enabled, o_rts=0 while full.
- Idle line with a 1-cycle low glitch → no strobe, back to IDLE. With the macro defined, a 1-cycle inverted glitch at a data-bit centre still yields the correct byte; without the macro the byte is corrupted.
